muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// The ALU opcode values mirror the core decoder's M-extension encodings.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ALUOP_WIDTH  = 5;

  localparam logic [ALUOP_WIDTH-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALUOP_WIDTH-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALUOP_WIDTH-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALUOP_WIDTH-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALUOP_WIDTH-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALUOP_WIDTH-1:0] ALU_REM    = 5'd21;

  localparam logic [XLEN_DEFAULT-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEFAULT-1:0] OVF_Q         = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic isMulDivOp(input logic [ALUOP_WIDTH-1:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring-divide step over the {high, low} accumulator halves.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   shiftReg,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] accNext,
  output logic [XLEN-1:0]   shiftNext
);

  logic [XLEN:0] addSum;
  logic [XLEN:0] remShift;
  logic [XLEN:0] diff;
  logic          noBorrow;

  always_comb begin
    addSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (shiftReg[0] ? {1'b0, operand} : '0);
    remShift = {acc[2*XLEN-1:XLEN], shiftReg[XLEN-1]};
    noBorrow = (remShift >= {1'b0, operand});
    diff     = remShift - {1'b0, operand};
    if (isDiv) begin
      // Dividend bits stream in MSB-first; quotient bits shift into the low half.
      accNext   = {(noBorrow ? diff[XLEN-1:0] : remShift[XLEN-1:0]), acc[XLEN-2:0], noBorrow};
      shiftNext = {shiftReg[XLEN-2:0], 1'b0};
    end else begin
      // Multiplier bits consumed LSB-first; the carry lands in the product MSB.
      accNext   = {addSum, acc[XLEN-1:1]};
      shiftNext = {1'b0, shiftReg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage RV32M sequencer: stalls the core while a 32-step multiply or
// divide runs on operand magnitudes, then retires the signed result in one pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Valid,
  input  logic [ALUOP_WIDTH-1:0] AluOperation,
  input  logic [XLEN-1:0]        SrcA,
  input  logic [XLEN-1:0]        SrcB,
  input  logic                   Kill,
  output logic                   Stall,
  output logic                   Done,
  output logic [XLEN-1:0]        Result,
  output logic                   Busy
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [2*XLEN-1:0]      acc;
  logic [XLEN-1:0]        shiftReg;
  logic [XLEN-1:0]        operand;
  logic [ALUOP_WIDTH-1:0] opReg;
  logic                   negQ;
  logic                   negR;

  logic            isM, isDivIn, signA, signB, divZero, divOvf, launch;
  logic [XLEN-1:0] magA, magB, fastResult, finalResult;
  logic [2*XLEN-1:0] stepAcc, product;
  logic [XLEN-1:0]   stepShift, quot, rem;
  logic              opIsDiv;

  always_comb begin
    isM     = isMulDivOp(AluOperation);
    isDivIn = (AluOperation == ALU_DIV) || (AluOperation == ALU_REM);
    signA   = (AluOperation != ALU_MULHU) && SrcA[XLEN-1];
    signB   = (AluOperation inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM}) && SrcB[XLEN-1];
    magA    = signA ? -SrcA : SrcA;
    magB    = signB ? -SrcB : SrcB;
    divZero = isDivIn && (SrcB == '0);
    divOvf  = isDivIn && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    if (divZero)
      fastResult = (AluOperation == ALU_REM) ? SrcA : DIV_BY_ZERO_Q;
    else
      fastResult = (AluOperation == ALU_REM) ? '0 : OVF_Q;
    launch  = (state == IDLE) && Valid && isM && !Kill;
  end

  assign Stall   = launch || (state == CALC);
  assign Busy    = (state != IDLE);
  assign opIsDiv = (opReg == ALU_DIV) || (opReg == ALU_REM);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .isDiv     (opIsDiv),
    .acc       (acc),
    .shiftReg  (shiftReg),
    .operand   (operand),
    .accNext   (stepAcc),
    .shiftNext (stepShift)
  );

  // Sign is applied once to the final iteration's output, never mid-run.
  always_comb begin
    product = negQ ? -stepAcc : stepAcc;
    quot    = negQ ? -stepAcc[XLEN-1:0] : stepAcc[XLEN-1:0];
    rem     = negR ? -stepAcc[2*XLEN-1:XLEN] : stepAcc[2*XLEN-1:XLEN];
    case (opReg)
      ALU_MUL:                         finalResult = product[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: finalResult = product[2*XLEN-1:XLEN];
      ALU_DIV:                         finalResult = quot;
      default:                         finalResult = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      shiftReg <= '0;
      operand  <= '0;
      opReg    <= '0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      Result   <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              opReg <= AluOperation;
              acc   <= '0;
              count <= '0;
              negQ  <= signA ^ signB;
              negR  <= signA;
              // Divide streams the dividend and subtracts the divisor; multiply
              // streams the multiplier and adds the multiplicand.
              shiftReg <= isDivIn ? magA : magB;
              operand  <= isDivIn ? magB : magA;
              if (divZero || divOvf) begin
                Result <= fastResult;
                Done   <= 1'b1;
                state  <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc      <= stepAcc;
            shiftReg <= stepShift;
            count    <= count + 1'b1;
            if (count == CW'(XLEN-1)) begin
              Result <= finalResult;
              Done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned results,
// fast paths, reset/kill aborts, back-to-back launches and non-M codes.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   Valid = 1'b0;
  logic                   Kill = 1'b0;
  logic [ALUOP_WIDTH-1:0] AluOperation = '0;
  logic [31:0]            SrcA = '0;
  logic [31:0]            SrcB = '0;
  logic                   Stall;
  logic                   Done;
  logic [31:0]            Result;
  logic                   Busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Valid        (Valid),
    .AluOperation (AluOperation),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .Kill         (Kill),
    .Stall        (Stall),
    .Done         (Done),
    .Result       (Result),
    .Busy         (Busy)
  );

  // Driver: called just after a rising edge; that cycle is cycle 1 (launch).
  task automatic run_op(input logic [ALUOP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stallN, output int doneAt, output logic [31:0] res);
    stallN = 0;
    doneAt = 0;
    res    = '0;
    Valid = 1'b1; AluOperation = op; SrcA = a; SrcB = b;
    for (int c = 1; c <= 40 && doneAt == 0; c++) begin
      @(negedge clk);
      if (Stall) stallN++;
      if (Done) begin doneAt = c; res = Result; end
      @(posedge clk); #1;
    end
    Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", Result); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_timing();
    int sN, dA; logic [31:0] r;
    run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, sN, dA, r);
    checks++; if (sN != 33) begin errors++; $display("FAIL mul_stall_cycles got %0d want 33", sN); end
    checks++; if (dA != 34) begin errors++; $display("FAIL mul_done_cycle got %0d want 34", dA); end
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
    @(negedge clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", Done); end
    checks++; if (Result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_held got %h want ffffffeb", Result); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after got %b want 0", Busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_variants();
    logic [ALUOP_WIDTH-1:0] ops[4];
    logic [31:0] as[4], bs[4], exps[4];
    int sN, dA; logic [31:0] r;
    ops  = '{ALU_MULH, ALU_MULHU, ALU_MULHSU, ALU_MUL};
    as   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0003};
    bs   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0005};
    exps = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h000B_000F};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], sN, dA, r);
      checks++; if (dA != 34) begin errors++; $display("FAIL mulv%0d_done_cycle got %0d want 34", i, dA); end
      checks++; if (r !== exps[i]) begin errors++; $display("FAIL mulv%0d_result got %h want %h", i, r, exps[i]); end
    end
  endtask

  task automatic test_div_rem();
    logic [ALUOP_WIDTH-1:0] ops[4];
    logic [31:0] as[4], bs[4], exps[4];
    int sN, dA; logic [31:0] r;
    ops  = '{ALU_DIV, ALU_REM, ALU_REM, ALU_DIV};
    as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd100};
    bs   = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd7};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd14};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], sN, dA, r);
      checks++; if (sN != 33) begin errors++; $display("FAIL div%0d_stall_cycles got %0d want 33", i, sN); end
      checks++; if (r !== exps[i]) begin errors++; $display("FAIL div%0d_result got %h want %h", i, r, exps[i]); end
    end
  endtask

  task automatic test_fast_path();
    logic [ALUOP_WIDTH-1:0] ops[4];
    logic [31:0] as[4], bs[4], exps[4];
    int sN, dA; logic [31:0] r;
    ops  = '{ALU_DIV, ALU_REM, ALU_DIV, ALU_REM};
    as   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], sN, dA, r);
      checks++; if (sN != 1) begin errors++; $display("FAIL fast%0d_stall_cycles got %0d want 1", i, sN); end
      checks++; if (dA != 2) begin errors++; $display("FAIL fast%0d_done_cycle got %0d want 2", i, dA); end
      checks++; if (r !== exps[i]) begin errors++; $display("FAIL fast%0d_result got %h want %h", i, r, exps[i]); end
    end
  endtask

  task automatic test_reset_mid_calc();
    int nDone;
    Valid = 1'b1; AluOperation = ALU_DIV; SrcA = 32'd1000; SrcB = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", Busy); end
    rst_n = 1'b0; Valid = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", Busy); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", Stall); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", Result); end
    @(posedge clk); #1; rst_n = 1'b1;
    nDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done) nDone++;
    end
    checks++; if (nDone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", nDone); end
    @(posedge clk); #1;
  endtask

  task automatic test_kill_mid_calc();
    int sN, dA, nDone; logic [31:0] r;
    run_op(ALU_MUL, 32'd3, 32'd5, sN, dA, r);
    checks++; if (r !== 32'd15) begin errors++; $display("FAIL kill_pre_result got %h want f", r); end
    Valid = 1'b1; AluOperation = ALU_DIV; SrcA = 32'd1000; SrcB = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    Kill = 1'b1;
    @(posedge clk); #1;
    Kill = 1'b0; Valid = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL kill_done got %b want 0", Done); end
    checks++; if (Result !== 32'd15) begin errors++; $display("FAIL kill_result_held got %h want f", Result); end
    nDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done) nDone++;
    end
    checks++; if (nDone != 0) begin errors++; $display("FAIL kill_no_done got %0d pulses want 0", nDone); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int nDone, d1, d2; logic [31:0] r1, r2;
    nDone = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    Valid = 1'b1; AluOperation = ALU_MUL; SrcA = 32'd3; SrcB = 32'd5;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (Done) begin
        nDone++;
        if (nDone == 1) begin d1 = c; r1 = Result; end
        else if (nDone == 2) begin d2 = c; r2 = Result; end
      end
      @(posedge clk); #1;
      if (nDone == 1 && c == d1) begin SrcA = 32'd6; SrcB = 32'hFFFF_FFFC; end
      if (nDone == 2 && c == d2) Valid = 1'b0;
    end
    Valid = 1'b0;
    checks++; if (nDone != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", nDone); end
    checks++; if (d1 != 34) begin errors++; $display("FAIL b2b_first_cycle got %0d want 34", d1); end
    checks++; if (d2 - d1 != 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", d2 - d1); end
    checks++; if (r1 !== 32'd15) begin errors++; $display("FAIL b2b_result1 got %h want f", r1); end
    checks++; if (r2 !== 32'hFFFF_FFE8) begin errors++; $display("FAIL b2b_result2 got %h want ffffffe8", r2); end
  endtask

  task automatic test_non_m_op();
    Valid = 1'b1; AluOperation = 5'd0; SrcA = 32'd9; SrcB = 32'd4;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL nonm_stall c%0d got %b want 0", c, Stall); end
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin
        errors++; $display("FAIL nonm_idle c%0d got busy %b done %b want 0 0", c, Busy, Done);
      end
    end
    @(posedge clk); #1;
    Valid = 1'b0;
  endtask

  task automatic test_kill_at_launch();
    Valid = 1'b1; AluOperation = ALU_MUL; SrcA = 32'd2; SrcB = 32'd2; Kill = 1'b1;
    @(negedge clk);
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL killlaunch_stall got %b want 0", Stall); end
    @(posedge clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL killlaunch_busy got %b want 0", Busy); end
    Kill = 1'b0; Valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_variants();
    test_div_rem();
    test_fast_path();
    test_reset_mid_calc();
    test_kill_mid_calc();
    test_back_to_back();
    test_non_m_op();
    test_kill_at_launch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
